bit_count_stream: RTL and testbench
===================================

Name: bit_count_stream

Overview:
Streaming, pipelined ones-counter for wide data words. It accepts one WIDTH-bit word per cycle over a valid/ready handshake and counts the ones in it with a 2-stage chunked adder tree. It also keeps a saturating running total across a frame delimited by in_last. It sits between a packet source and statistics/threshold logic that needs per-word and per-frame ones counts at full throughput.

Parameters:
WIDTH, 32, input word width in bits (>=2).
CHUNK, 8, bits counted per stage-1 chunk; WIDTH must be a multiple of CHUNK (elaboration error otherwise).
ACC_W, 16, width of the frame accumulator; must be >= CW (defined below).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word valid.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  word to count.
in_last  input  1  word is the final word of its frame.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
word_count  output  CW=$clog2(WIDTH+1)  ones in the word.
frame_count  output  ACC_W  running ones total of the frame, including this word.
frame_done  output  1  this result belongs to the in_last word.
acc_sat  output  1  frame_count is saturated at 2^ACC_W-1.

Behaviour:
- Reset (async assert, sync-released by the system): out_valid=0, word_count=0, frame_count=0, frame_done=0, acc_sat=0, both pipeline valid flags 0, accumulator 0. in_ready=1 once reset is released.
- Handshake: a transfer occurs when valid&&ready on the same edge. in_ready is combinational: !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready. in_ready has no dependency on in_valid.
- Stage 1 (registered on input transfer): computes per-chunk counts of WIDTH/CHUNK chunks, each $clog2(CHUNK+1) bits; captures in_last.
- Stage 2 / output register (loaded when s1_valid && s2_advance): word_count = sum of the chunk counts; frame_count = acc + word_count with saturation; frame_done = last; acc_sat = saturated.
- Latency: 2 cycles from the input transfer to out_valid. With out_ready held high, throughput is 1 word/cycle.
- Backpressure: the output holds stable while out_valid && !out_ready. Stage 1 holds when stage 2 cannot advance, and in_ready then drops.
- Accumulator: updates only when stage 2 loads. The next value is 0 if the loaded word was last, otherwise the saturated sum. A frame start is implicit: the first word after a last word, or after reset.
- Saturation: if acc + word_count > 2^ACC_W-1, the result clamps to the maximum and acc_sat=1. acc_sat is sticky for the remaining results of the frame and clears with the accumulator on frame_done.
- Single-word frame (in_last on the first word): frame_count = word_count, frame_done=1.
- All-zero word: word_count=0; the accumulator is unchanged but still advances the frame.
- Reset mid-frame: in-flight words are discarded and the accumulator is cleared. No partial result is emitted.
- out_valid deasserts only after the consumer accepts the result, with no new result loaded in that cycle.

Optional Feature:
BIT_COUNT_STREAM_PARITY_EN: when defined, adds output port word_parity (1 bit). It equals the XOR of in_data for the same result, is registered alongside word_count, resets to 0 and follows the same hold rules. When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bit_count_pkg: CW/chunk-count width helper functions, the saturation max constant as a function of ACC_W, and a stage-1 struct typedef (chunk count array, last flag).
- Sub-module bit_count_chunk: purely combinational, parameter CHUNK, CHUNK-bit input, $clog2(CHUNK+1)-bit count output. Instantiated WIDTH/CHUNK times in a generate loop.

Test Plan:
- Reset, then send 0xFFFFFFFF (last=0), 0x0000000F (last=1), out_ready=1 -> results at +2 and +3 cycles: word_count 32/4, frame_count 32/36, frame_done 0/1.
- Stream 8 words 0xA5A5A5A5, last on the 8th, out_ready=1 -> one result/cycle, in_ready stays 1, word_count=16 each, frame_count 16..128, then the next frame starts at its own first word's count.
- Same stream with out_ready toggled 1,0,0,1 -> no drop or duplication, outputs stable while stalled, in_ready=0 when both stages are full, sequence matches the unstalled case.
- ACC_W=8, send 9 words of 0xFFFFFFFF in one frame -> frame_count 32,64,...,224, then 255 with acc_sat=1 from word 8. The next frame restarts with frame_count=32, acc_sat=0.
- Assert rst_n low for 1 cycle mid-frame with 2 words in flight -> out_valid=0 immediately, no stale result afterwards, next word 0x00000001 last=1 gives frame_count=1.
- With BIT_COUNT_STREAM_PARITY_EN: 0x00000007 -> word_parity=1; 0x00000003 -> word_parity=0.

Source files
------------

// File: rtl/bit_count_pkg.sv
// Shared helpers for the bit_count_stream ones-counter: count widths and
// the accumulator saturation ceiling.
package bit_count_pkg;

   // Bits needed to hold a ones count of 0..bits.
   function automatic int count_w(input int bits);
      return $clog2(bits + 1);
   endfunction

   // Largest value an acc_w-bit accumulator can hold.
   function automatic longint unsigned sat_max(input int acc_w);
      return (64'd1 << acc_w) - 64'd1;
   endfunction

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;
   localparam int DEF_ACC_W = 16;

endpackage

// File: rtl/bit_count_chunk.sv
// Combinational ones count of one CHUNK-bit slice of the input word.
module bit_count_chunk
   import bit_count_pkg::*;
#(
   parameter  int CHUNK = DEF_CHUNK,
   localparam int CCW   = count_w(CHUNK)
) (
   input  logic [CHUNK-1:0] i_bits,
   output logic [CCW-1:0]   o_count
);

   // NOTE: every variable written in always_comb gets a default first,
   // so no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         o_count = o_count + CCW'(i_bits[i]);
      end
   end

endmodule

// File: rtl/bit_count_stream.sv
// Streaming 2-stage ones counter with a saturating per-frame running total.
// Optional macro BIT_COUNT_STREAM_PARITY_EN adds the word_parity output.
module bit_count_stream
   import bit_count_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int CHUNK = DEF_CHUNK,
   parameter  int ACC_W = DEF_ACC_W,
   localparam int CW    = count_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    word_count,
   output logic [ACC_W-1:0] frame_count,
   output logic             frame_done,
   output logic             acc_sat
`ifdef BIT_COUNT_STREAM_PARITY_EN
   ,
   output logic             word_parity
`endif
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CCW = count_w(CHUNK);
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));

   typedef struct packed {
      logic [NCH-1:0][CCW-1:0] cnt;
      logic                    last;
   } s1_t;

   if (WIDTH < 2) begin : g_bad_width
      $error("bit_count_stream: WIDTH must be >= 2");
   end
   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("bit_count_stream: WIDTH must be a multiple of CHUNK");
   end
   if (ACC_W < CW) begin : g_bad_acc
      $error("bit_count_stream: ACC_W must be >= CW");
   end

   logic [NCH-1:0][CCW-1:0] w_chunk_cnt;
   logic                    w_s2_advance;
   logic                    w_s2_load;
   logic [CW-1:0]           w_word_sum;
   logic [ACC_W:0]          w_acc_sum;
   logic                    w_ovf;
   logic                    w_frame_sat;
   logic [ACC_W-1:0]        w_frame_val;

   logic                    r_s1_valid;
   s1_t                     r_s1;
   logic                    r_out_valid;
   logic [CW-1:0]           r_word_count;
   logic [ACC_W-1:0]        r_frame_count;
   logic                    r_frame_done;
   logic                    r_acc_sat;
   logic [ACC_W-1:0]        r_acc;
   logic                    r_frame_sat;

   for (genvar g = 0; g < NCH; g++) begin : g_chunk
      bit_count_chunk #(.CHUNK(CHUNK)) u_chunk (
         .i_bits  (in_data[g*CHUNK +: CHUNK]),
         .o_count (w_chunk_cnt[g])
      );
   end

   assign w_s2_advance = !r_out_valid || out_ready;
   assign w_s2_load    = r_s1_valid && w_s2_advance;
   assign in_ready     = !r_s1_valid || w_s2_advance;

   always_comb begin
      w_word_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         w_word_sum = w_word_sum + CW'(r_s1.cnt[i]);
      end
   end

   // Once the frame has saturated the accumulator sits at SAT_MAX, so any
   // further non-zero count overflows again and the clamp stays put.
   assign w_acc_sum   = {1'b0, r_acc} + (ACC_W+1)'(w_word_sum);
   assign w_ovf       = w_acc_sum[ACC_W];
   assign w_frame_sat = r_frame_sat || w_ovf;
   assign w_frame_val = w_ovf ? SAT_MAX : w_acc_sum[ACC_W-1:0];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1.cnt  <= w_chunk_cnt;
            r_s1.last <= in_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid   <= 1'b0;
         r_word_count  <= '0;
         r_frame_count <= '0;
         r_frame_done  <= 1'b0;
         r_acc_sat     <= 1'b0;
         r_acc         <= '0;
         r_frame_sat   <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid   <= 1'b1;
         r_word_count  <= w_word_sum;
         r_frame_count <= w_frame_val;
         r_frame_done  <= r_s1.last;
         r_acc_sat     <= w_frame_sat;
         r_acc         <= r_s1.last ? '0 : w_frame_val;
         r_frame_sat   <= r_s1.last ? 1'b0 : w_frame_sat;
      end else if (out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign word_count  = r_word_count;
   assign frame_count = r_frame_count;
   assign frame_done  = r_frame_done;
   assign acc_sat     = r_acc_sat;

`ifdef BIT_COUNT_STREAM_PARITY_EN
   logic r_s1_parity;
   logic r_word_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_parity   <= 1'b0;
         r_word_parity <= 1'b0;
      end else begin
         if (in_ready && in_valid) begin
            r_s1_parity <= ^in_data;
         end
         if (w_s2_load) begin
            r_word_parity <= r_s1_parity;
         end
      end
   end

   assign word_parity = r_word_parity;
`endif

endmodule

// File: tb/tb_bit_count_stream.sv
// Scoreboard bench for bit_count_stream (ACC_W=8 so saturation is reachable).
module tb_bit_count_stream;

   localparam int WIDTH = 32;
   localparam int ACC_W = 8;
   localparam int CW    = 6;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    word_count;
   logic [ACC_W-1:0] frame_count;
   logic             frame_done;
   logic             acc_sat;
`ifdef BIT_COUNT_STREAM_PARITY_EN
   logic             word_parity;
`endif

   bit_count_stream #(.WIDTH(WIDTH), .CHUNK(8), .ACC_W(ACC_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .word_count  (word_count),
      .frame_count (frame_count),
      .frame_done  (frame_done),
      .acc_sat     (acc_sat)
`ifdef BIT_COUNT_STREAM_PARITY_EN
      ,
      .word_parity (word_parity)
`endif
   );

   typedef struct {
      logic [CW-1:0]    wc;
      logic [ACC_W-1:0] fc;
      logic             done;
      logic             sat;
      logic             par;
      logic             chk_lat;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycle    = 0;
   bit   tog_en   = 0;
   int   stalls;
   int   total_stalls;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // out_ready pattern 1,0,0,1 applied while tog_en is set
   initial begin
      automatic int ph = 0;
      automatic logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) begin
            out_ready = pat[ph % 4];
            ph++;
         end
      end
   end

   // Monitor: compares outputs on accept and checks stability while stalled.
   initial begin
      automatic bit   held = 0;
      automatic logic [CW+ACC_W+1:0] held_vec = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 0;
            continue;
         end
         if (held) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_stable", {word_count, frame_count, frame_done, acc_sat}, held_vec);
         end
         held = 0;
         if (out_valid) begin
            if (!out_ready) begin
               held     = 1;
               held_vec = {word_count, frame_count, frame_done, acc_sat};
            end else if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result word_count=%0d frame_count=%0d", word_count, frame_count);
            end else begin
               e = sb.pop_front();
               check("word_count", word_count, e.wc);
               check("frame_count", frame_count, e.fc);
               check("frame_done", frame_done, e.done);
               check("acc_sat", acc_sat, e.sat);
`ifdef BIT_COUNT_STREAM_PARITY_EN
               check("word_parity", word_parity, e.par);
`endif
               if (e.chk_lat) check("latency", cycle - e.cyc, 2);
            end
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic last,
                       input logic [CW-1:0] wc, input logic [ACC_W-1:0] fc,
                       input logic done, input logic sat, input logic lat,
                       output int n_stall);
      exp_t e;
      bit   acc = 0;
      n_stall  = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (in_ready) begin
            acc       = 1;
            e.wc      = wc;
            e.fc      = fc;
            e.done    = done;
            e.sat     = sat;
            e.par     = ^d;
            e.chk_lat = lat;
            e.cyc     = cycle;
            sb.push_back(e);
         end else begin
            n_stall++;
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout data=%0h never accepted", d);
      end
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
      @(negedge clk);
      check("drain_pending", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_a5_frame(input logic lat, output int st);
      int s;
      st = 0;
      for (int i = 1; i <= 8; i++) begin
         send(32'hA5A5_A5A5, i == 8, 6'd16, 8'(16 * i), i == 8, 1'b0, lat, s);
         st += s;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_word_count", word_count, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_acc_sat", acc_sat, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Two-word frame, full-throughput latency
      send(32'hFFFF_FFFF, 1'b0, 6'd32, 8'd32, 1'b0, 1'b0, 1'b1, stalls);
      send(32'h0000_000F, 1'b1, 6'd4,  8'd36, 1'b1, 1'b0, 1'b1, stalls);
      drain();

      // Eight-word frame at one word per cycle, then a single-word frame
      send_a5_frame(1'b1, total_stalls);
      send(32'h0000_00FF, 1'b1, 6'd8, 8'd8, 1'b1, 1'b0, 1'b1, stalls);
      total_stalls += stalls;
      check("in_ready_held_high", total_stalls, 0);
      drain();

      // All-zero word leaves the total unchanged mid-frame
      send(32'h0000_0003, 1'b0, 6'd2, 8'd2, 1'b0, 1'b0, 1'b0, stalls);
      send(32'h0000_0000, 1'b0, 6'd0, 8'd2, 1'b0, 1'b0, 1'b0, stalls);
      send(32'h8000_0000, 1'b1, 6'd1, 8'd3, 1'b1, 1'b0, 1'b0, stalls);
      drain();

      // Same eight-word frame under out_ready backpressure
      tog_en = 1;
      send_a5_frame(1'b0, total_stalls);
      check("in_ready_dropped", total_stalls > 0, 1'b1);
      drain();
      @(posedge clk);
      #2;
      tog_en    = 0;
      out_ready = 1'b1;

      // Saturation: 9 full words in one frame, then a fresh frame
      for (int i = 1; i <= 9; i++) begin
         send(32'hFFFF_FFFF, i == 9, 6'd32, (i <= 7) ? 8'(32 * i) : 8'd255,
              i == 9, i >= 8, 1'b0, stalls);
      end
      send(32'hFFFF_FFFF, 1'b1, 6'd32, 8'd32, 1'b1, 1'b0, 1'b0, stalls);
      drain();

      // Reset with two words in flight
      out_ready = 1'b0;
      send(32'h0000_00FF, 1'b0, 6'd8, 8'd8, 1'b0, 1'b0, 1'b0, stalls);
      send(32'h0000_FFFF, 1'b0, 6'd16, 8'd24, 1'b0, 1'b0, 1'b0, stalls);
      @(negedge clk);
      check("inflight_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_frame_count", frame_count, 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_stale_result", out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(32'h0000_0001, 1'b1, 6'd1, 8'd1, 1'b1, 1'b0, 1'b1, stalls);
      drain();

      // Parity vectors (word_parity checked when the option is built in)
      send(32'h0000_0007, 1'b1, 6'd3, 8'd3, 1'b1, 1'b0, 1'b0, stalls);
      send(32'h0000_0003, 1'b1, 6'd2, 8'd2, 1'b1, 1'b0, 1'b0, stalls);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
